// File: rtl/riscv_fwd_ctrl.sv
// Forwarding and load-use hazard controller for a 5-stage RISC-V pipeline.
// Shadows rd/we/ld through EX/MEM/WB and steers the two EX operand muxes.
module riscv_fwd_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_hold,
    input  logic              i_flush,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_id_use_rs1,
    input  logic              i_id_use_rs2,
    input  logic [REG_AW-1:0] i_id_rd,
    input  logic              i_id_we,
    input  logic              i_id_ld,
    output logic [1:0]        o_fwd_sel_a,
    output logic [1:0]        o_fwd_sel_b,
    output logic              o_stall,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    logic [REG_AW-1:0] r_ex_rs1;
    logic [REG_AW-1:0] r_ex_rs2;
    logic [REG_AW-1:0] r_ex_rd;
    logic              r_ex_use1;
    logic              r_ex_use2;
    logic              r_ex_we;
    logic              r_ex_ld;
    logic [REG_AW-1:0] r_mem_rd;
    logic              r_mem_we;
    logic              r_mem_ld;
    logic [REG_AW-1:0] r_wb_rd;
    logic              r_wb_we;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_ex_eff;
    logic w_mem_eff;
    logic w_wb_eff;
    logic w_lu;
    logic w_bubble;

    // x0 is hardwired zero, so writes to it never forward and never hazard.
    assign w_ex_eff  = r_ex_we  && (r_ex_rd  != '0);
    assign w_mem_eff = r_mem_we && (r_mem_rd != '0);
    assign w_wb_eff  = r_wb_we  && (r_wb_rd  != '0);

    assign w_lu = r_ex_ld && w_ex_eff &&
                  ((i_id_use_rs1 && (r_ex_rd == i_id_rs1)) ||
                   (i_id_use_rs2 && (r_ex_rd == i_id_rs2)));

    assign o_stall     = w_lu && !i_flush && !i_hold;
    assign w_bubble    = i_flush || w_lu;
    assign o_stall_cnt = r_stall_cnt;

    // A load still in MEM has no ALU result yet, so it never selects 01.
    always_comb begin
        o_fwd_sel_a = 2'b00;
        o_fwd_sel_b = 2'b00;
        if (r_ex_use1) begin
            if (w_mem_eff && !r_mem_ld && (r_mem_rd == r_ex_rs1)) begin
                o_fwd_sel_a = 2'b01;
            end else if (w_wb_eff && (r_wb_rd == r_ex_rs1)) begin
                o_fwd_sel_a = 2'b10;
            end
        end
        if (r_ex_use2) begin
            if (w_mem_eff && !r_mem_ld && (r_mem_rd == r_ex_rs2)) begin
                o_fwd_sel_b = 2'b01;
            end else if (w_wb_eff && (r_wb_rd == r_ex_rs2)) begin
                o_fwd_sel_b = 2'b10;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_ex_rs1    <= '0;
            r_ex_rs2    <= '0;
            r_ex_rd     <= '0;
            r_ex_use1   <= 1'b0;
            r_ex_use2   <= 1'b0;
            r_ex_we     <= 1'b0;
            r_ex_ld     <= 1'b0;
            r_mem_rd    <= '0;
            r_mem_we    <= 1'b0;
            r_mem_ld    <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_we     <= 1'b0;
            r_stall_cnt <= '0;
        end else if (!i_hold) begin
            r_mem_rd <= r_ex_rd;
            r_mem_we <= r_ex_we;
            r_mem_ld <= r_ex_ld;
            r_wb_rd  <= r_mem_rd;
            r_wb_we  <= r_mem_we;
            if (w_bubble) begin
                r_ex_rs1  <= '0;
                r_ex_rs2  <= '0;
                r_ex_rd   <= '0;
                r_ex_use1 <= 1'b0;
                r_ex_use2 <= 1'b0;
                r_ex_we   <= 1'b0;
                r_ex_ld   <= 1'b0;
            end else begin
                r_ex_rs1  <= i_id_rs1;
                r_ex_rs2  <= i_id_rs2;
                r_ex_rd   <= i_id_rd;
                r_ex_use1 <= i_id_use_rs1;
                r_ex_use2 <= i_id_use_rs2;
                r_ex_we   <= i_id_we;
                r_ex_ld   <= i_id_ld;
            end
            // A taken flush squashes the consumer, so no stall cycle is spent.
            if (w_lu && !i_flush && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_riscv_fwd_ctrl.sv
// Directed bench for riscv_fwd_ctrl: per-cycle expectations queued by the
// driver, popped and compared on the falling edge by an independent monitor.
module tb_riscv_fwd_ctrl;

    localparam int CNT_W = 4;
    localparam int W     = 2 + 2 + 1 + CNT_W;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } instr_t;

    logic             clk;
    logic             rst_n;
    logic             hold;
    logic             flush;
    instr_t           id;
    logic [1:0]       sel_a;
    logic [1:0]       sel_b;
    logic             stall;
    logic [CNT_W-1:0] cnt;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks;
    int           failures;
    int           model_cnt;

    riscv_fwd_ctrl #(.REG_AW(5), .CNT_W(CNT_W)) dut (
        .i_clk        (clk),
        .i_rstn       (rst_n),
        .i_hold       (hold),
        .i_flush      (flush),
        .i_id_rs1     (id.rs1),
        .i_id_rs2     (id.rs2),
        .i_id_use_rs1 (id.u1),
        .i_id_use_rs2 (id.u2),
        .i_id_rd      (id.rd),
        .i_id_we      (id.we),
        .i_id_ld      (id.ld),
        .o_fwd_sel_a  (sel_a),
        .o_fwd_sel_b  (sel_b),
        .o_stall      (stall),
        .o_stall_cnt  (cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: run did not finish within bound");
        $fatal(1, "timeout");
    end

    function automatic instr_t nop();
        return '0;
    endfunction

    function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        instr_t t;
        t = '{rs1: rs1, rs2: rs2, u1: 1'b1, u2: 1'b1, rd: rd, we: 1'b1, ld: 1'b0};
        return t;
    endfunction

    function automatic instr_t lw(input logic [4:0] rd, input logic [4:0] rs1);
        instr_t t;
        t = '{rs1: rs1, rs2: 5'd0, u1: 1'b1, u2: 1'b0, rd: rd, we: 1'b1, ld: 1'b1};
        return t;
    endfunction

    // driver: one ID instruction per cycle plus the outputs expected that cycle
    task automatic step(input string nm, input instr_t ins, input logic fl, input logic hd,
                        input logic [1:0] ea, input logic [1:0] eb, input logic es,
                        input logic [CNT_W-1:0] ec, input logic rst_pulse);
        @(posedge clk);
        #1;
        id    = ins;
        flush = fl;
        hold  = hd;
        exp_q.push_back({ea, eb, es, ec});
        name_q.push_back(nm);
        if (rst_pulse) begin
            #1;
            rst_n = 1'b0;
        end
    endtask

    task automatic drain(input logic [CNT_W-1:0] ec);
        for (int i = 0; i < 3; i++) begin
            step("drain", nop(), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, ec, 1'b0);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            logic [W-1:0] g;
            string        n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            g = {sel_a, sel_b, stall, cnt};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL %s: got sel_a=%b sel_b=%b stall=%b cnt=%0d, want sel_a=%b sel_b=%b stall=%b cnt=%0d",
                         n, g[W-1 -: 2], g[W-3 -: 2], g[CNT_W], g[CNT_W-1:0],
                         e[W-1 -: 2], e[W-3 -: 2], e[CNT_W], e[CNT_W-1:0]);
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        hold     = 1'b0;
        flush    = 1'b0;
        id       = '0;

        step("reset", nop(), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        drain(4'd0);

        // back-to-back ALU dependency forwards from MEM
        step("t1_p", alu(5'd5, 5'd1, 5'd2), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0);
        step("t1_c", alu(5'd6, 5'd5, 5'd1), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0);
        step("t1_ex", nop(),                1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 4'd0, 1'b0);
        drain(4'd0);

        // MEM wins over WB when both wrote the same register
        step("pr_1", alu(5'd5, 5'd1, 5'd2), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0);
        step("pr_2", alu(5'd5, 5'd1, 5'd2), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0);
        step("pr_c", alu(5'd6, 5'd5, 5'd5), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0);
        step("pr_ex", nop(),                1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 4'd0, 1'b0);
        drain(4'd0);

        // distance-two dependency forwards from WB
        step("t2_p", alu(5'd5, 5'd1, 5'd2), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0);
        step("t2_n", nop(),                 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0);
        step("t2_c", alu(5'd7, 5'd1, 5'd5), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0);
        step("t2_ex", nop(),                1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 4'd0, 1'b0);
        drain(4'd0);

        // load-use: one stall, bubble, then WB forwarding
        step("t3_ld",  lw(5'd8, 5'd1),        1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0);
        step("t3_stl", alu(5'd9, 5'd8, 5'd8), 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 4'd0, 1'b0);
        step("t3_bub", alu(5'd9, 5'd8, 5'd8), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd1, 1'b0);
        step("t3_ex",  nop(),                 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 4'd1, 1'b0);
        drain(4'd1);

        // x0 never forwards and never hazards
        step("t4_w0",  alu(5'd0, 5'd1, 5'd2), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd1, 1'b0);
        step("t4_r0",  alu(5'd3, 5'd0, 5'd0), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd1, 1'b0);
        step("t4_mem", lw(5'd0, 5'd1),        1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd1, 1'b0);
        step("t4_ldu", alu(5'd4, 5'd0, 5'd0), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd1, 1'b0);
        step("t4_ex",  nop(),                 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd1, 1'b0);
        drain(4'd1);

        // flush beats load-use
        step("t5f_ld",  lw(5'd8, 5'd1),        1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd1, 1'b0);
        step("t5f_fl",  alu(5'd9, 5'd8, 5'd8), 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 4'd1, 1'b0);
        step("t5f_nx",  alu(5'd9, 5'd8, 5'd8), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd1, 1'b0);
        step("t5f_ex",  nop(),                 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 4'd1, 1'b0);
        drain(4'd1);

        // hold freezes a pending load-use until release
        step("t5h_ld",  lw(5'd8, 5'd1),        1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd1, 1'b0);
        step("t5h_h1",  alu(5'd9, 5'd8, 5'd8), 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 4'd1, 1'b0);
        step("t5h_h2",  alu(5'd9, 5'd8, 5'd8), 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 4'd1, 1'b0);
        step("t5h_stl", alu(5'd9, 5'd8, 5'd8), 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 4'd1, 1'b0);
        step("t5h_bub", alu(5'd9, 5'd8, 5'd8), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd2, 1'b0);
        step("t5h_ex",  nop(),                 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 4'd2, 1'b0);
        drain(4'd2);

        // hold keeps a MEM forward visible
        step("hf_p",  alu(5'd5, 5'd1, 5'd2), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd2, 1'b0);
        step("hf_c",  alu(5'd6, 5'd5, 5'd1), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd2, 1'b0);
        step("hf_h1", nop(),                 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 4'd2, 1'b0);
        step("hf_h2", nop(),                 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 4'd2, 1'b0);
        step("hf_r",  nop(),                 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 4'd2, 1'b0);
        step("hf_nx", nop(),                 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd2, 1'b0);
        drain(4'd2);

        // counter saturation across 20 load-use events
        model_cnt = 2;
        for (int k = 0; k < 20; k++) begin
            step("t6_ld",  lw(5'd8, 5'd1),        1'b0, 1'b0, 2'b00, 2'b00, 1'b0, CNT_W'(model_cnt), 1'b0);
            step("t6_stl", alu(5'd9, 5'd8, 5'd8), 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, CNT_W'(model_cnt), 1'b0);
            if (model_cnt < 15) model_cnt++;
            step("t6_bub", alu(5'd9, 5'd8, 5'd8), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, CNT_W'(model_cnt), 1'b0);
            step("t6_ex",  nop(),                 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, CNT_W'(model_cnt), 1'b0);
        end
        step("t6_sat", nop(), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'hF, 1'b0);

        // asynchronous reset in the middle of a stall cycle
        step("rst_ld",  lw(5'd8, 5'd1),        1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'hF, 1'b0);
        step("rst_mid", alu(5'd9, 5'd8, 5'd8), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd0, 1'b1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        step("rst_after", alu(5'd9, 5'd8, 5'd8), 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0);
        step("rst_ex",    nop(),                 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0);

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected entries never compared, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
